// File: rtl/shift_register_sequencer_if.sv
// Command and shift-unit bundle for shift_register_sequencer.
// The slave side is the sequencer; the master side is whoever issues commands and hosts the shift unit.
interface shift_register_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic             rotate;
  logic             serialIn;
  logic [WIDTH-1:0] loadData;
  logic [WIDTH-1:0] shiftExit;
  logic             shiftSerialMsb;
  logic             shiftSerialLsb;
  logic [WIDTH-1:0] shiftData;
  logic [1:0]       shiftSelect;
  logic             shiftIr;
  logic             shiftIl;
  logic [WIDTH-1:0] q;
  logic             serialOut;
  logic             busy;
  logic             done;

  modport slave (
    input  start, op, count, rotate, serialIn, loadData,
    input  shiftExit, shiftSerialMsb, shiftSerialLsb,
    output shiftData, shiftSelect, shiftIr, shiftIl,
    output q, serialOut, busy, done
  );

  modport master (
    output start, op, count, rotate, serialIn, loadData,
    output shiftExit, shiftSerialMsb, shiftSerialLsb,
    input  shiftData, shiftSelect, shiftIr, shiftIl,
    input  q, serialOut, busy, done
  );
endinterface

// File: rtl/shift_register_sequencer.sv
// Sequencer owning the register in front of a 4-bit combinational shift unit:
// runs load, clear and multi-step shift/rotate commands through start/busy/done.
module shift_register_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  shift_register_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic             rotate_q, rotate_d;
  logic             serialOut_q, serialOut_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             inRun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= OP_LOAD;
      rotate_q    <= 1'b0;
      serialOut_q <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      op_q        <= op_d;
      rotate_q    <= rotate_d;
      serialOut_q <= serialOut_d;
      remaining_q <= remaining_d;
    end
  end

  // Command latching happens only in IDLE; in RUN the register follows the shift unit
  // while op_q selects which serial bit is reported as shifted out.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    op_d        = op_q;
    rotate_d    = rotate_q;
    serialOut_d = serialOut_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          rotate_d = bus.rotate;
          unique case (bus.op)
            OP_LOAD: begin
              data_d  = bus.loadData;
              state_d = DONE;
            end
            OP_CLEAR: begin
              remaining_d = CNT_W'(1);
              state_d     = RUN;
            end
            default: begin
              if (bus.count != '0) begin
                remaining_d = bus.count;
                state_d     = RUN;
              end else begin
                state_d = DONE;
              end
            end
          endcase
        end
      end
      RUN: begin
        data_d      = bus.shiftExit;
        remaining_d = remaining_q - CNT_W'(1);
        if (op_q == OP_LEFT) begin
          serialOut_d = bus.shiftSerialMsb;
        end else if (op_q == OP_RIGHT) begin
          serialOut_d = bus.shiftSerialLsb;
        end
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign inRun = (state_q == RUN);

  assign bus.shiftData   = data_q;
  assign bus.q           = data_q;
  assign bus.serialOut   = serialOut_q;
  assign bus.busy        = inRun;
  assign bus.done        = (state_q == DONE);
  assign bus.shiftSelect = inRun ? op_q : 2'b00;
  // Rotate feeds the bit leaving one end back into the other; otherwise serialIn is used live.
  assign bus.shiftIr     = (inRun && rotate_q) ? bus.shiftSerialMsb : bus.serialIn;
  assign bus.shiftIl     = (inRun && rotate_q) ? bus.shiftSerialLsb : bus.serialIn;

endmodule
